// File: rtl/bram_byte_arbiter.sv
// Two-client byte-wide arbiter for a 256x32 BlockRAM tile used as a 1024x8 memory.
// Zero-fills the tile after reset (optional), then grants one read or write per cycle round-robin.
module bram_byte_arbiter #(
    parameter int READ_ADDRESS_MSB_FROM_DATALSB  = 24,
    parameter int WRITE_ADDRESS_MSB_FROM_DATALSB = 16,
    parameter int WRITE_ENABLE_FROM_DATA         = 20,
    parameter int REG_OUT                        = 0,
    parameter int CLEAR_ON_RESET                 = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [9:0]  a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [7:0]  a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [9:0]  b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [7:0]  b_rdata,

    output logic        busy,
    output logic [5:0]  bram_cfg,
    output logic [7:0]  bram_rd_addr,
    output logic [7:0]  bram_wr_addr,
    output logic [31:0] bram_wr_data,
    input  logic [31:0] bram_rd_data
);

    localparam int   DEPTH       = 1 + REG_OUT;
    localparam logic LP_REG_OUT  = (REG_OUT != 0);
    localparam logic LP_CLEAR    = (CLEAR_ON_RESET != 0);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t           r_state;
    logic [7:0]       r_clr_cnt;
    logic             r_last_b;
    logic [DEPTH-1:0] r_pv;
    logic [DEPTH-1:0] r_pid;
    logic [7:0]       r_a_rdata;
    logic [7:0]       r_b_rdata;

    logic             w_run;
    logic             w_a_gnt;
    logic             w_b_gnt;
    logic             w_any;
    logic             w_we;
    logic [9:0]       w_addr;
    logic [7:0]       w_wdata;
    logic             w_rd_issue;
    logic             w_a_rvalid;
    logic             w_b_rvalid;
    logic [5:0]       w_cfg;
    logic [7:0]       w_wr_addr;
    logic [7:0]       w_rd_addr;
    logic [31:0]      w_wr_data;
    logic             w_unused_rd;

    assign w_run   = (r_state == S_RUN);

    // Tie goes to the client that did not win the previous grant.
    assign w_a_gnt = w_run && a_req && (!b_req || r_last_b);
    assign w_b_gnt = w_run && b_req && !w_a_gnt;
    assign w_any   = w_a_gnt || w_b_gnt;

    assign w_we       = w_b_gnt ? b_we    : a_we;
    assign w_addr     = w_b_gnt ? b_addr  : a_addr;
    assign w_wdata    = w_b_gnt ? b_wdata : a_wdata;
    assign w_rd_issue = w_any && !w_we;

    always_comb begin
        w_cfg     = '0;
        w_wr_addr = '0;
        w_rd_addr = '0;
        w_wr_data = '0;
        if (!w_run) begin
            w_cfg     = {LP_REG_OUT, 5'b10100};
            w_wr_addr = r_clr_cnt;
        end else begin
            w_cfg = {LP_REG_OUT, 5'b00101};
            if (w_any) begin
                w_wr_addr = w_addr[7:0];
                w_rd_addr = w_addr[7:0];
                w_wr_data[7:0] = w_wdata;
                w_wr_data[WRITE_ADDRESS_MSB_FROM_DATALSB +: 2] = w_addr[9:8];
                w_wr_data[READ_ADDRESS_MSB_FROM_DATALSB +: 2]  = w_addr[9:8];
                w_wr_data[WRITE_ENABLE_FROM_DATA]              = w_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= LP_CLEAR ? S_CLEAR : S_RUN;
            r_clr_cnt <= '0;
            r_last_b  <= 1'b1;
            r_pv      <= '0;
            r_pid     <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 8'd1;
                    if (r_clr_cnt == 8'hFF) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_any) begin
                        r_last_b <= w_b_gnt;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase

            r_pv[0]  <= w_rd_issue;
            r_pid[0] <= w_b_gnt;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pid[i] <= r_pid[i-1];
            end

            if (w_a_rvalid) begin
                r_a_rdata <= bram_rd_data[7:0];
            end
            if (w_b_rvalid) begin
                r_b_rdata <= bram_rd_data[7:0];
            end
        end
    end

    // The last pipeline stage lines up with the tile's output, so data is passed
    // straight through in the rvalid cycle and the captured copy is held afterwards.
    assign w_a_rvalid = r_pv[DEPTH-1] && !r_pid[DEPTH-1];
    assign w_b_rvalid = r_pv[DEPTH-1] &&  r_pid[DEPTH-1];

    assign w_unused_rd = ^bram_rd_data[31:8];

    assign a_gnt        = w_a_gnt;
    assign b_gnt        = w_b_gnt;
    assign a_rvalid     = w_a_rvalid;
    assign b_rvalid     = w_b_rvalid;
    assign a_rdata      = w_a_rvalid ? bram_rd_data[7:0] : r_a_rdata;
    assign b_rdata      = w_b_rvalid ? bram_rd_data[7:0] : r_b_rdata;
    assign busy         = !w_run;
    assign bram_cfg     = w_cfg;
    assign bram_wr_addr = w_wr_addr;
    assign bram_rd_addr = w_rd_addr;
    assign bram_wr_data = w_wr_data;

endmodule
